// File: rtl/con_port_arbiter.sv
// con_port_arbiter
//   Round-robin arbiter that shares the single protocol-side datamem port
//   among N_REQ protocol controllers (UART, SPI, I2C, ...). The winning
//   request is registered onto con_write/con_addr/con_in. The synchronous-read
//   result is routed back on rdata together with a one-hot ack to the
//   requester that issued the access.
//
//   Timing, for a request sampled in cycle T:
//     T+1  gnt pulse, with con_* presented to datamem
//     T+2  ack pulse, with rdata = con_out
//
//   Ports
//     con_clk    controller clock (single domain)
//     rst        asynchronous, active-high reset
//     req        per-requester request, held until its gnt
//     req_we     byte write enables, requester i at [4i+3:4i] (0 = read)
//     req_addr   word address, requester i at slice i
//     req_wdata  big-endian write data, requester i at slice i
//     req_lock   burst lock request (CON_ARB_LOCK_EN builds only)
//     gnt        one-hot pulse: request accepted
//     ack        one-hot pulse: access completed
//     rdata      read data, valid while any ack bit is high
//     con_write  to datamem con_write
//     con_addr   to datamem con_addr
//     con_in     to datamem con_in
//     con_out    from datamem con_out (1-cycle synchronous read)
//
//   Build option
//     CON_ARB_LOCK_EN  When defined, a winner that grants with req_lock set
//                      keeps exclusive ownership. The lock is released by a
//                      grant with req_lock clear, or by 4 consecutive cycles
//                      without its req.
module con_port_arbiter #(
   parameter int N_REQ     = 3,
   parameter int ADDR_BITS = 14,
   parameter int DATA_W    = 32
) (
   input  logic                        con_clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req,
   input  logic [4*N_REQ-1:0]          req_we,
   input  logic [ADDR_BITS*N_REQ-1:0]  req_addr,
   input  logic [DATA_W*N_REQ-1:0]     req_wdata,
   input  logic [N_REQ-1:0]            req_lock,
   output logic [N_REQ-1:0]            gnt,
   output logic [N_REQ-1:0]            ack,
   output logic [DATA_W-1:0]           rdata,
   output logic [3:0]                  con_write,
   output logic [ADDR_BITS-1:0]        con_addr,
   output logic [DATA_W-1:0]           con_in,
   input  logic [DATA_W-1:0]           con_out
);

   localparam int ID_W = $clog2(N_REQ);
   typedef logic [ID_W-1:0] id_t;

   id_t                 rr_ptr;
   logic [N_REQ-1:0]    elig_p0;
   id_t                 cand_p0;
   logic                win_vld_p0;
   id_t                 win_id_p0;
   logic [3:0]          sel_we_p0;
   logic [ADDR_BITS-1:0] sel_addr_p0;
   logic [DATA_W-1:0]   sel_wdata_p0;
   logic                vld_p1;
   id_t                 id_p1;
   logic                vld_p2;
   id_t                 id_p2;

`ifdef CON_ARB_LOCK_EN
   logic                lock_q;
   id_t                 lock_id;
   logic [1:0]          lock_tmo;
   logic [N_REQ-1:0]    lock_mask;

   always_comb begin
      lock_mask          = '0;
      lock_mask[lock_id] = 1'b1;
   end

   // A new grant (re)evaluates the lock. While locked and idle, consecutive
   // cycles without req[lock_id] count toward the release timeout.
   always_ff @(posedge con_clk or posedge rst) begin
      if (rst) begin
         lock_q   <= 1'b0;
         lock_id  <= '0;
         lock_tmo <= 2'd0;
      end else if (win_vld_p0) begin
         lock_q   <= req_lock[win_id_p0];
         lock_id  <= win_id_p0;
         lock_tmo <= 2'd0;
      end else if (lock_q) begin
         if (req[lock_id]) begin
            lock_tmo <= 2'd0;
         end else if (lock_tmo == 2'd3) begin
            lock_q   <= 1'b0;
            lock_tmo <= 2'd0;
         end else begin
            lock_tmo <= lock_tmo + 2'd1;
         end
      end
   end
`else
   logic unused_req_lock;
   assign unused_req_lock = ^req_lock;
`endif

   // Stage p0: arbitration. The requester granted last cycle is masked out.
   // The descending search lets the closest candidate after rr_ptr win.
   always_comb begin
      elig_p0 = req & ~gnt;
`ifdef CON_ARB_LOCK_EN
      if (lock_q) elig_p0 = elig_p0 & lock_mask;
`endif
      win_vld_p0 = 1'b0;
      win_id_p0  = rr_ptr;
      cand_p0    = rr_ptr;
      for (int k = N_REQ; k >= 1; k--) begin
         cand_p0 = id_t'((int'(rr_ptr) + k) % N_REQ);
         if (elig_p0[cand_p0]) begin
            win_vld_p0 = 1'b1;
            win_id_p0  = cand_p0;
         end
      end
      sel_we_p0    = '0;
      sel_addr_p0  = '0;
      sel_wdata_p0 = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (win_id_p0 == id_t'(i)) begin
            sel_we_p0    = req_we[4*i +: 4];
            sel_addr_p0  = req_addr[ADDR_BITS*i +: ADDR_BITS];
            sel_wdata_p0 = req_wdata[DATA_W*i +: DATA_W];
         end
      end
   end

   // Stage p1: grant registered, access presented on the datamem port
   always_ff @(posedge con_clk or posedge rst) begin
      if (rst) begin
         rr_ptr    <= id_t'(N_REQ - 1);
         vld_p1    <= 1'b0;
         id_p1     <= '0;
         con_write <= 4'd0;
         con_addr  <= '0;
         con_in    <= '0;
      end else begin
         vld_p1 <= win_vld_p0;
         if (win_vld_p0) begin
            rr_ptr    <= win_id_p0;
            id_p1     <= win_id_p0;
            con_write <= sel_we_p0;
            con_addr  <= sel_addr_p0;
            con_in    <= sel_wdata_p0;
         end else begin
            con_write <= 4'd0;
         end
      end
   end

   // Stage p2: datamem read data returns, ack the issuing requester
   always_ff @(posedge con_clk or posedge rst) begin
      if (rst) begin
         vld_p2 <= 1'b0;
         id_p2  <= '0;
      end else begin
         vld_p2 <= vld_p1;
         id_p2  <= id_p1;
      end
   end

   always_comb begin
      gnt = '0;
      ack = '0;
      if (vld_p1) gnt[id_p1] = 1'b1;
      if (vld_p2) ack[id_p2] = 1'b1;
   end

   assign rdata = vld_p2 ? con_out : '0;

endmodule
